sd_writer: RTL and testbench
============================

Name: sd_writer

Overview:
- Host-side SD sector write data path: the DAT0 (1-bit bus) transmit counterpart of the sector read engine.
- After the top-level FSM has issued CMD24 through sdcmd_ctrl, this block clocks one 512-byte data block out on DAT0, then collects the card's CRC-status token and waits for busy release.
- It owns DAT0 only. It follows the sdclk produced by sdcmd_ctrl and generates no clock of its own.

Parameters:
- PRE_BITS, 8, number of sdclk periods DAT0 is driven high before the start bit (Nwr ≥ 2).
- TIMEOUT, 1000000, maximum sdclk rising edges to wait for the status start bit, and separately for busy release.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset (0: reset, 1: working)
- sdclk  input  1  SD clock from sdcmd_ctrl (sync with clk)
- sddat0  inout  1  SD DAT0; driven when the block owns the bus, else 'z'
- wstart  input  1  one-clk pulse: start writing one sector; ignored while wbusy=1
- wbusy  output  1  high from the clk after an accepted wstart until wdone
- wdone  output  1  one-clk pulse when the operation ends (success or error)
- werr  output  1  valid with wdone: 1 = token ≠ 3'b010 or timeout
- wstat  output  3  CRC-status token captured from the card; 3'b111 on timeout
- inreq  output  1  one-clk byte fetch request to the sector buffer
- inaddr  output  9  byte address 0..511 for inreq
- inbyte  input  8  buffer read data, valid exactly 1 clk after inreq

Behaviour:
- Reset values: DAT0 released ('z', oe=0), wbusy=0, wdone=0, werr=0, wstat=0, inreq=0, inaddr=0, state=IDLE. Reset mid-operation releases DAT0 immediately.
- Edge detection: register sdclkl <= sdclk.
  - Falling edge (sdclkl & ~sdclk): update the driven bit.
  - Rising edge (~sdclkl & sdclk): sample DAT0 and advance counters.
- IDLE: DAT0 released. On wstart: pulse inreq with inaddr=0, then go to PRE.
- Byte capture: inbyte is loaded into nextbyte 1 clk after every inreq.
- PRE: drive 1 for PRE_BITS falling edges, then go to START.
- START: drive 0 for one bit and move nextbyte into the shift register. Then go to DATA with bit index = 0.
- DATA: 4096 bits, MSB first per byte, byte 0 first.
  - Each driven bit is fed to the CRC16 on the same falling edge.
  - On bit index[2:0]==0 with byte k < 511: pulse inreq with inaddr=k+1.
  - On index[2:0]==7: the next falling edge reloads the shift register from nextbyte.
  - After bit 4095 go to CRC.
- CRC: drive CRC16 MSB first for 16 bits, then END.
- END: drive 1 for one bit. On the next falling edge release DAT0, zero the counter and go to STAT.
- STAT:
  - Wait for DAT0=0 sampled on a rising edge (token start bit).
  - Then sample 3 bits into wstat, MSB first, then go to BUSY.
  - If TIMEOUT rising edges pass with no start bit: wstat=3'b111, go to FIN.
- BUSY:
  - Skip the token end bit.
  - Wait for DAT0 sampled 1 on a rising edge, then go to FIN.
  - After TIMEOUT rising edges with DAT0 still low: force wstat=3'b111, go to FIN.
- FIN: pulse wdone for 1 clk, werr = (wstat≠3'b010), then return to IDLE. wstat holds until the next accepted wstart.
- CRC16: CCITT polynomial x^16+x^12+x^5+1, init 0, covers the data bits only, cleared in IDLE.
- Latency: wstart to first PRE bit is at the next sdclk falling edge. There are 4122 driven bit times in total: PRE_BITS + 1 start + 4096 data + 16 CRC + 1 end.
- Simultaneous events: wstart while wbusy=1 is ignored. The sdclk edge on the same clk as wstart is not counted.
- Counters: 32-bit; the timeout compare is ≥ TIMEOUT.

Decomposition:
- Shared sd_pkg:
  - state enum {IDLE, PRE, START, DATA, CRC, END, STAT, BUSY, FIN}
  - token constants: TOK_OK=3'b010, TOK_CRCERR=3'b101, TOK_WRERR=3'b110, TOK_TIMEOUT=3'b111
  - CRC16 polynomial 16'h1021
- Sub-module sd_crc16: bit-serial, with clr, en and din inputs and crc[15:0] output; reusable for read-side CRC checking.

Test Plan:
- Sector all 8'h00, card model returns token 010 then holds busy for 100 sdclk → DAT0 carries CRC 16'h0000; wdone with werr=0, wstat=3'b010; exactly 4122 driven bit times.
- Sector all 8'hFF → CRC bits equal 16'h7FA1; inaddr sequence 0..511 with each address requested once, in order.
- Sector byte n = n[7:0], model returns 101 → wdone, werr=1, wstat=3'b101; checker verifies MSB-first serialisation of every byte.
- Model never drives a start bit, TIMEOUT=1000 in simulation → wdone after 1000 rising edges, wstat=3'b111, werr=1, DAT0 released.
- Busy held low beyond TIMEOUT → wstat=3'b111, werr=1. A second wstart issued mid-DATA is ignored (one wdone only).
- rstn asserted mid-DATA → DAT0 'z' and wbusy=0 within the same clk. A subsequent wstart completes normally with werr=0.

Source files
------------

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD data-path states, token codes and CRC16 constants
package sd_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE  = 4'd0;
    localparam state_t ST_PRE   = 4'd1;
    localparam state_t ST_START = 4'd2;
    localparam state_t ST_DATA  = 4'd3;
    localparam state_t ST_CRC   = 4'd4;
    localparam state_t ST_END   = 4'd5;
    localparam state_t ST_STAT  = 4'd6;
    localparam state_t ST_BUSY  = 4'd7;
    localparam state_t ST_FIN   = 4'd8;

    localparam logic [2:0] TOK_OK      = 3'b010;
    localparam logic [2:0] TOK_CRCERR  = 3'b101;
    localparam logic [2:0] TOK_WRERR   = 3'b110;
    localparam logic [2:0] TOK_TIMEOUT = 3'b111;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // One bit-serial step of CRC16-CCITT (MSB-first shift register)
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc16.sv
// rtl/sd_crc16.sv - bit-serial CRC16-CCITT generator/checker for SD DAT lines
module sd_crc16
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    // Clear has priority so a new block always starts from zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc <= 16'h0000;
        end else if (clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end
    end

endmodule

// File: rtl/sd_writer.sv
// rtl/sd_writer.sv - DAT0 single-sector write engine with CRC-status and busy wait
module sd_writer
    import sd_pkg::*;
#(
    parameter int PRE_BITS = 8,
    parameter int TIMEOUT  = 1000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sdclk,
    inout  wire        sddat0,
    input  logic       wstart,
    output logic       wbusy,
    output logic       wdone,
    output logic       werr,
    output logic [2:0] wstat,
    output logic       inreq,
    output logic [8:0] inaddr,
    input  logic [7:0] inbyte
);

    localparam logic [31:0] PRE_LAST = PRE_BITS - 1;
    localparam logic [31:0] TO_LIM   = TIMEOUT;

    state_t      state;
    logic        sdclkl;
    logic        fall;
    logic        rise;
    logic        dat_oe;
    logic        dat_out;
    logic        dat_in;
    logic [31:0] cnt;
    logic [11:0] bidx;
    logic [7:0]  shreg;
    logic [7:0]  nextbyte;
    logic        inreq_d;
    logic        phase;
    logic [1:0]  tcnt;
    logic [15:0] crc;

    assign fall   = sdclkl & ~sdclk;
    assign rise   = ~sdclkl & sdclk;
    assign sddat0 = dat_oe ? dat_out : 1'bz;
    assign dat_in = sddat0;

    sd_crc16 u_crc (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state == ST_IDLE),
        .en   ((state == ST_DATA) && fall),
        .din  (shreg[7]),
        .crc  (crc)
    );

    // Edge history of sdclk and one-deep prefetch of the next sector byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sdclkl   <= 1'b0;
            inreq_d  <= 1'b0;
            nextbyte <= 8'h00;
        end else begin
            sdclkl  <= sdclk;
            inreq_d <= inreq;
            if (inreq_d) begin
                nextbyte <= inbyte;
            end
        end
    end

    // Write sequencer: drive bits on sdclk falls, sample the card on rises
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            dat_oe  <= 1'b0;
            dat_out <= 1'b1;
            wbusy   <= 1'b0;
            wdone   <= 1'b0;
            werr    <= 1'b0;
            wstat   <= 3'b000;
            inreq   <= 1'b0;
            inaddr  <= 9'd0;
            cnt     <= 32'd0;
            bidx    <= 12'd0;
            shreg   <= 8'h00;
            phase   <= 1'b0;
            tcnt    <= 2'd0;
        end else begin
            wdone <= 1'b0;
            inreq <= 1'b0;
            case (state)
                ST_IDLE: begin
                    dat_oe <= 1'b0;
                    if (wstart) begin
                        wbusy  <= 1'b1;
                        werr   <= 1'b0;
                        wstat  <= 3'b000;
                        inreq  <= 1'b1;
                        inaddr <= 9'd0;
                        cnt    <= 32'd0;
                        state  <= ST_PRE;
                    end
                end
                ST_PRE: if (fall) begin
                    dat_oe  <= 1'b1;
                    dat_out <= 1'b1;
                    if (cnt == PRE_LAST) begin
                        cnt   <= 32'd0;
                        state <= ST_START;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_START: if (fall) begin
                    dat_out <= 1'b0;
                    shreg   <= nextbyte;
                    bidx    <= 12'd0;
                    state   <= ST_DATA;
                end
                ST_DATA: if (fall) begin
                    dat_out <= shreg[7];
                    // Fetch byte k+1 while byte k is still shifting out
                    if (bidx[2:0] == 3'd0 && bidx[11:3] != 9'd511) begin
                        inreq  <= 1'b1;
                        inaddr <= bidx[11:3] + 9'd1;
                    end
                    shreg <= (bidx[2:0] == 3'd7) ? nextbyte : {shreg[6:0], 1'b0};
                    if (bidx == 12'd4095) begin
                        cnt   <= 32'd0;
                        state <= ST_CRC;
                    end else begin
                        bidx <= bidx + 12'd1;
                    end
                end
                ST_CRC: if (fall) begin
                    dat_out <= crc[4'd15 - cnt[3:0]];
                    if (cnt[3:0] == 4'd15) begin
                        cnt   <= 32'd0;
                        state <= ST_END;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                // First fall drives the end bit, second fall hands DAT0 to the card
                ST_END: if (fall) begin
                    if (cnt == 32'd0) begin
                        dat_out <= 1'b1;
                        cnt     <= 32'd1;
                    end else begin
                        dat_oe <= 1'b0;
                        cnt    <= 32'd0;
                        phase  <= 1'b0;
                        tcnt   <= 2'd0;
                        state  <= ST_STAT;
                    end
                end
                ST_STAT: if (rise) begin
                    if (!phase) begin
                        if (!dat_in) begin
                            phase <= 1'b1;
                        end else if (cnt + 32'd1 >= TO_LIM) begin
                            wstat <= TOK_TIMEOUT;
                            state <= ST_FIN;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end else begin
                        wstat <= {wstat[1:0], dat_in};
                        if (tcnt == 2'd2) begin
                            cnt   <= 32'd0;
                            phase <= 1'b0;
                            state <= ST_BUSY;
                        end else begin
                            tcnt <= tcnt + 2'd1;
                        end
                    end
                end
                // phase=0 swallows the token end bit before busy is observed
                ST_BUSY: if (rise) begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else if (dat_in) begin
                        state <= ST_FIN;
                    end else if (cnt + 32'd1 >= TO_LIM) begin
                        wstat <= TOK_TIMEOUT;
                        state <= ST_FIN;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_FIN: begin
                    wdone <= 1'b1;
                    werr  <= (wstat != TOK_OK);
                    wbusy <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_writer.sv
// tb/tb_sd_writer.sv - directed self-checking bench for sd_writer
module tb_sd_writer;
    import sd_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sdclk = 1'b0;
    logic       wstart = 1'b0;
    logic [7:0] inbyte = 8'h00;
    logic       card_oe = 1'b0;
    logic       card_bit = 1'b1;
    wire        sddat0;
    logic       wbusy, wdone, werr, inreq;
    logic [2:0] wstat;
    logic [8:0] inaddr;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [512];
    logic       cap [4200];
    int         nbits = 0;
    int         rise_cnt = 0;
    int         wdone_cnt = 0;
    logic [8:0] addrq [$];

    bit         done_seen;
    logic       d_err, d_busy;
    logic [2:0] d_stat;
    int         d_rises;
    int         wd0;

    pullup (sddat0);
    assign sddat0 = card_oe ? card_bit : 1'bz;

    sd_writer #(.PRE_BITS(8), .TIMEOUT(1000)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .sdclk  (sdclk),
        .sddat0 (sddat0),
        .wstart (wstart),
        .wbusy  (wbusy),
        .wdone  (wdone),
        .werr   (werr),
        .wstat  (wstat),
        .inreq  (inreq),
        .inaddr (inaddr),
        .inbyte (inbyte)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        sdclk = ~sdclk;
    end

    initial forever begin
        @(posedge sdclk);
        rise_cnt++;
        if (dut.dat_oe) begin
            if (nbits < 4200) cap[nbits] = sddat0;
            nbits++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (inreq) begin
            inbyte = mem[inaddr];
            addrq.push_back(inaddr);
        end
        if (wdone) wdone_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] crc_ref();
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'h0000;
        for (int k = 0; k < 512; k++) begin
            b = mem[k];
            for (int j = 7; j >= 0; j--) begin
                fb = b[j] ^ c[15];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    // mode 0: token + finite busy, 1: card silent, 2: token + busy never released
    task automatic do_write(input int mode, input logic [2:0] tok, input int busy_len, input bit second);
        bit rel;
        nbits = 0;
        addrq.delete();
        card_oe = 1'b0;
        card_bit = 1'b1;
        done_seen = 1'b0;
        wstart = 1'b1;
        tick(1);
        wstart = 1'b0;
        chk("wbusy_accept", {31'd0, wbusy}, 32'd1);
        if (second) begin
            tick(300);
            wstart = 1'b1;
            tick(1);
            wstart = 1'b0;
        end
        rel = 1'b0;
        for (int i = 0; i < 12000 && !rel; i++) begin
            tick(1);
            if (nbits > 0 && !dut.dat_oe) rel = 1'b1;
        end
        chk("release", {31'd0, rel}, 32'd1);
        d_rises = rise_cnt;
        if (mode != 1) begin
            repeat (2) @(negedge sdclk);
            card_oe = 1'b1;
            card_bit = 1'b0;
            for (int b = 2; b >= 0; b--) begin
                @(negedge sdclk);
                card_bit = tok[b];
            end
            @(negedge sdclk);
            card_bit = 1'b1;
            @(negedge sdclk);
            card_bit = 1'b0;
            if (mode == 0) begin
                repeat (busy_len) @(negedge sdclk);
                card_bit = 1'b1;
            end
        end
        tick(1);
        for (int i = 0; i < 4000 && !done_seen; i++) begin
            if (wdone) begin
                done_seen = 1'b1;
                d_err = werr;
                d_stat = wstat;
                d_busy = wbusy;
                d_rises = rise_cnt - d_rises;
            end else begin
                tick(1);
            end
        end
        chk("done_seen", {31'd0, done_seen}, 32'd1);
        chk("wbusy_at_done", {31'd0, d_busy}, 32'd0);
        tick(1);
        chk("done_pulse", {31'd0, wdone}, 32'd0);
        card_oe = 1'b0;
        card_bit = 1'b1;
    endtask

    task automatic check_frame(input logic [15:0] exp_crc);
        int m;
        logic [7:0]  bv;
        logic [15:0] c;
        chk("bit_times", nbits, 4122);
        m = 0;
        for (int i = 0; i < 8; i++) if (cap[i] !== 1'b1) m++;
        chk("pre_bits", m, 0);
        chk("start_bit", {31'd0, cap[8]}, 32'd0);
        m = 0;
        for (int i = 0; i < 4096; i++) begin
            bv = mem[i / 8];
            if (cap[9 + i] !== bv[7 - (i % 8)]) m++;
        end
        chk("data_bits", m, 0);
        c = 16'h0000;
        for (int i = 0; i < 16; i++) c = {c[14:0], cap[4105 + i]};
        chk("crc16", {16'd0, c}, {16'd0, exp_crc});
        chk("end_bit", {31'd0, cap[4121]}, 32'd1);
        chk("addr_count", addrq.size(), 512);
        m = 0;
        for (int i = 0; i < addrq.size(); i++) if (addrq[i] !== i[8:0]) m++;
        chk("addr_order", m, 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        tick(3);
        chk("rst_wbusy", {31'd0, wbusy}, 32'd0);
        chk("rst_wdone", {31'd0, wdone}, 32'd0);
        chk("rst_werr", {31'd0, werr}, 32'd0);
        chk("rst_wstat", {29'd0, wstat}, 32'd0);
        chk("rst_inreq", {31'd0, inreq}, 32'd0);
        chk("rst_inaddr", {23'd0, inaddr}, 32'd0);
        chk("rst_oe", {31'd0, dut.dat_oe}, 32'd0);
        rstn = 1'b1;
        tick(2);

        // all-zero sector, good token
        do_write(0, TOK_OK, 100, 1'b0);
        chk("t1_werr", {31'd0, d_err}, 32'd0);
        chk("t1_wstat", {29'd0, d_stat}, {29'd0, TOK_OK});
        check_frame(16'h0000);
        tick(5);

        // all-ones sector
        for (int i = 0; i < 512; i++) mem[i] = 8'hFF;
        do_write(0, TOK_OK, 100, 1'b0);
        chk("t2_werr", {31'd0, d_err}, 32'd0);
        check_frame(16'h7FA1);
        tick(5);

        // ramp sector, CRC error token
        for (int i = 0; i < 512; i++) mem[i] = i[7:0];
        do_write(0, TOK_CRCERR, 20, 1'b0);
        chk("t3_werr", {31'd0, d_err}, 32'd1);
        chk("t3_wstat", {29'd0, d_stat}, 32'd5);
        check_frame(crc_ref());
        tick(5);

        // card never answers: status timeout
        do_write(1, TOK_OK, 0, 1'b0);
        chk("t4_werr", {31'd0, d_err}, 32'd1);
        chk("t4_wstat", {29'd0, d_stat}, 32'd7);
        chk("t4_rises", d_rises, 1000);
        chk("t4_oe", {31'd0, dut.dat_oe}, 32'd0);
        tick(5);

        // busy never released, extra wstart mid-DATA
        wd0 = wdone_cnt;
        do_write(2, TOK_OK, 0, 1'b1);
        tick(20);
        chk("t5_werr", {31'd0, d_err}, 32'd1);
        chk("t5_wstat", {29'd0, d_stat}, 32'd7);
        chk("t5_one_done", wdone_cnt - wd0, 1);
        chk("t5_addr_count", addrq.size(), 512);

        // reset mid-DATA then a clean write
        wstart = 1'b1;
        tick(1);
        wstart = 1'b0;
        tick(400);
        rstn = 1'b0;
        #1;
        chk("t6_rst_oe", {31'd0, dut.dat_oe}, 32'd0);
        chk("t6_rst_wbusy", {31'd0, wbusy}, 32'd0);
        tick(2);
        rstn = 1'b1;
        tick(2);
        do_write(0, TOK_OK, 50, 1'b0);
        chk("t6_werr", {31'd0, d_err}, 32'd0);
        chk("t6_wstat", {29'd0, d_stat}, {29'd0, TOK_OK});
        check_frame(crc_ref());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
